// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU (port 0) and a loader (port 1)
// with a registered round-robin grant, a bounded burst per owner and registered read data.
// Ports:
//   clk_i, reset_ni                 clock, asynchronous active-low reset
//   reqN_i, weN_i, addrN_i, wdataN_i requester N: request, write select, byte address, write data
//   gntN_o                          requester N owns the memory this cycle
//   rvalidN_o, rdataN_o             read data returned one cycle after an accepted read
//   mem_*                           combinational datamem interface driven by the accepted beat
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int BURST_MAX = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_write_enable_o,
  output logic              mem_read_enable_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);
  localparam int CW = BURST_MAX > 1 ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  state_e          state_q, state_d;
  logic            last_owner_q, last_owner_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            acc0, acc1, acc, acc_we, own1, req_own, req_oth;
  logic            rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  assign gnt0_o = state_q == OWN0;
  assign gnt1_o = state_q == OWN1;
  assign acc0   = gnt0_o & req0_i;
  assign acc1   = gnt1_o & req1_i;
  assign acc    = acc0 | acc1;
  assign acc_we = acc0 ? we0_i : we1_i;
  assign mem_write_enable_o = acc & acc_we;
  assign mem_read_enable_o  = acc & ~acc_we;
  assign mem_address_o      = acc0 ? addr0_i : acc1 ? addr1_i : '0;
  assign mem_write_data_o   = acc0 ? wdata0_i : acc1 ? wdata1_i : '0;
  assign own1    = state_q == OWN1;
  assign req_own = own1 ? req1_i : req0_i;
  assign req_oth = own1 ? req0_i : req1_i;
  // A tie in IDLE goes to the port that did not own last; the burst limit only
  // forces a handover when the other port is actually waiting, otherwise the
  // counter parks at its maximum.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    if (state_q == IDLE) begin
      beat_cnt_d = '0;
      if (req0_i & (~req1_i | last_owner_q)) state_d = OWN0;
      else if (req1_i) state_d = OWN1;
    end else if (~req_own | (acc & req_oth & (beat_cnt_q == CNT_MAX))) begin
      state_d      = req_oth ? (own1 ? OWN0 : OWN1) : IDLE;
      last_owner_d = own1;
      beat_cnt_d   = '0;
    end else if (acc & (beat_cnt_q != CNT_MAX)) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= acc0 & ~we0_i;
      rvalid1_q <= acc1 & ~we1_i;
      if (acc0 & ~we0_i) rdata0_q <= mem_read_data_i;
      if (acc1 & ~we1_i) rdata1_q <= mem_read_data_i;
    end
  end
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_dmem_arbiter;
  localparam int BM = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rv0, rv1, mwe, mre;
  logic [63:0] rd0, rd1, maddr, mwd, mrd;
  logic [63:0] dmem [16];
  logic bk_we = 1'b0;
  logic [3:0] bk_idx = '0;
  logic [63:0] bk_wd = '0;
  int wr_pulses = 0;
  int tests = 0, fails = 0;
  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .BURST_MAX(BM)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rv0), .rvalid1_o(rv1),
    .rdata0_o(rd0), .rdata1_o(rd1),
    .mem_address_o(maddr), .mem_write_enable_o(mwe), .mem_read_enable_o(mre),
    .mem_write_data_o(mwd), .mem_read_data_i(mrd)
  );
  always #5 clk = ~clk;
  assign mrd = dmem[maddr[6:3]];
  always @(posedge clk) begin
    if (mwe) dmem[maddr[6:3]] <= mwd;
    else if (bk_we) dmem[bk_idx] <= bk_wd;
    if (mwe) wr_pulses <= wr_pulses + 1;
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask
  task automatic poke(input int idx, input logic [63:0] val);
    bk_idx = 4'(idx); bk_wd = val; bk_we = 1'b1;
    nxt();
    bk_we = 1'b0;
  endtask
  task automatic test_reset;
    clr();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) poke(i, 64'h0);
    req0 = 1; req1 = 1;
    nxt(); nxt();
    tests++;
    if ({gnt0, gnt1, rv0, rv1, mwe, mre} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 000000", {gnt0, gnt1, rv0, rv1, mwe, mre});
    end
    tests++;
    if ({rd0, rd1} !== 128'h0) begin
      fails++; $display("FAIL reset_rdata: got %h/%h expected 0/0", rd0, rd1);
    end
    rst_n = 1'b1;
    nxt();
    tests++;
    if ({gnt0, gnt1, mre} !== 3'b101) begin
      fails++; $display("FAIL reset_first_tie: got gnt0,gnt1,re=%b expected 101", {gnt0, gnt1, mre});
    end
    req0 = 0; req1 = 0;
    #1;
    tests++;
    if ({gnt0, mre, mwe, maddr} !== {3'b100, 64'h0}) begin
      fails++; $display("FAIL req_drop_no_access: got gnt0=%b re=%b we=%b addr=%h expected 1 0 0 0", gnt0, mre, mwe, maddr);
    end
    nxt();
    tests++;
    if ({gnt0, gnt1, rv0} !== 3'b000) begin
      fails++; $display("FAIL req_drop_leave: got gnt0,gnt1,rv0=%b expected 000", {gnt0, gnt1, rv0});
    end
  endtask
  task automatic test_single_read;
    clr();
    poke(2, 64'hDEAD);
    req0 = 1; addr0 = 64'h10;
    #1;
    tests++;
    if (gnt0 !== 1'b0) begin
      fails++; $display("FAIL read_cycle0_gnt: got %b expected 0", gnt0);
    end
    nxt();
    tests++;
    if ({gnt0, mre, mwe, maddr} !== {3'b110, 64'h10}) begin
      fails++; $display("FAIL read_cycle1: got gnt0=%b re=%b we=%b addr=%h expected 1 1 0 10", gnt0, mre, mwe, maddr);
    end
    nxt();
    req0 = 0;
    #1;
    tests++;
    if ({rv0, rd0} !== {1'b1, 64'hDEAD}) begin
      fails++; $display("FAIL read_cycle2_data: got rv0=%b rd0=%h expected 1 dead", rv0, rd0);
    end
    nxt();
    tests++;
    if ({rv0, rd0} !== {1'b0, 64'hDEAD}) begin
      fails++; $display("FAIL read_hold: got rv0=%b rd0=%h expected 0 dead", rv0, rd0);
    end
  endtask
  task automatic test_contention;
    clr();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req0 = 1; req1 = 1;
    nxt();
    for (int k = 0; k < 3 * BM; k++) begin
      logic e0;
      e0 = ((k / BM) % 2) == 0;
      tests++;
      if ({gnt0, gnt1, mre} !== {e0, ~e0, 1'b1}) begin
        fails++; $display("FAIL contention_beat%0d: got gnt0,gnt1,re=%b expected %b", k, {gnt0, gnt1, mre}, {e0, ~e0, 1'b1});
      end
      nxt();
    end
    clr();
    nxt(); nxt();
  endtask
  task automatic test_solo_burst;
    clr();
    req1 = 1; addr1 = 64'h08;
    nxt();
    for (int k = 0; k < 10; k++) begin
      tests++;
      if ({gnt0, gnt1, mre} !== 3'b011) begin
        fails++; $display("FAIL solo_beat%0d: got gnt0,gnt1,re=%b expected 011", k, {gnt0, gnt1, mre});
      end
      nxt();
    end
    req0 = 1;
    #1;
    tests++;
    if ({gnt0, gnt1} !== 2'b01) begin
      fails++; $display("FAIL solo_last_beat: got gnt0,gnt1=%b expected 01", {gnt0, gnt1});
    end
    nxt();
    tests++;
    if ({gnt0, gnt1} !== 2'b10) begin
      fails++; $display("FAIL solo_handover: got gnt0,gnt1=%b expected 10", {gnt0, gnt1});
    end
    clr();
    nxt(); nxt();
  endtask
  task automatic test_write_read;
    int base;
    clr();
    base = wr_pulses;
    req1 = 1; we1 = 1; addr1 = 64'h40; wdata1 = 64'hCAFE;
    nxt();
    tests++;
    if ({gnt1, mwe, mre, maddr, mwd} !== {3'b110, 64'h40, 64'hCAFE}) begin
      fails++; $display("FAIL write_beat: got gnt1=%b we=%b re=%b addr=%h wd=%h expected 1 1 0 40 cafe", gnt1, mwe, mre, maddr, mwd);
    end
    nxt();
    req1 = 0; we1 = 0; req0 = 1; addr0 = 64'h40;
    #1;
    tests++;
    if (dmem[8] !== 64'hCAFE) begin
      fails++; $display("FAIL write_commit: got %h expected cafe", dmem[8]);
    end
    nxt();
    tests++;
    if ({gnt0, mre, maddr} !== {2'b11, 64'h40}) begin
      fails++; $display("FAIL readback_beat: got gnt0=%b re=%b addr=%h expected 1 1 40", gnt0, mre, maddr);
    end
    nxt();
    req0 = 0;
    #1;
    tests++;
    if ({rv0, rd0} !== {1'b1, 64'hCAFE}) begin
      fails++; $display("FAIL readback_data: got rv0=%b rd0=%h expected 1 cafe", rv0, rd0);
    end
    tests++;
    if (wr_pulses - base !== 1) begin
      fails++; $display("FAIL write_pulses: got %0d expected 1", wr_pulses - base);
    end
    nxt(); nxt();
  endtask
  task automatic test_midburst_reset;
    clr();
    poke(3, 64'h5555);
    req0 = 1;
    nxt();
    nxt();
    we0 = 1; addr0 = 64'h18; wdata0 = 64'h1234;
    #1;
    tests++;
    if (mwe !== 1'b1) begin
      fails++; $display("FAIL midburst_pending_write: got %b expected 1", mwe);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mwe, gnt0, rv0, rd0} !== 67'h0) begin
      fails++; $display("FAIL midburst_async: got we=%b gnt0=%b rv0=%b rd0=%h expected 0 0 0 0", mwe, gnt0, rv0, rd0);
    end
    nxt();
    tests++;
    if (dmem[3] !== 64'h5555) begin
      fails++; $display("FAIL midburst_mem: got %h expected 5555", dmem[3]);
    end
    clr();
    rst_n = 1'b1;
    nxt();
  endtask
  task automatic test_random;
    logic        pr [2], pw [2], pacc [2], ex_rv [2];
    logic [63:0] pa [2], pd [2], ex_rd [2], ref_mem [16];
    logic [63:0] e_addr, e_wd;
    logic        e_we, e_re, a0, a1;
    int owner, last, run, ax;
    clr();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      poke(i, 64'h0);
      ref_mem[i] = '0;
    end
    rst_n = 1'b1;
    owner = -1; last = 1; run = 0;
    for (int p = 0; p < 2; p++) begin
      pr[p] = 0; pw[p] = 0; pa[p] = '0; pd[p] = '0; pacc[p] = 0; ex_rv[p] = 0; ex_rd[p] = '0;
    end
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pr[p] || pacc[p]) begin
          pr[p] = $urandom_range(0, 2) != 0;
          pw[p] = 1'($urandom_range(0, 1));
          pa[p] = 64'($urandom_range(0, 15)) << 3;
          pd[p] = {$urandom, $urandom};
        end
      end
      req0 = pr[0]; we0 = pw[0]; addr0 = pa[0]; wdata0 = pd[0];
      req1 = pr[1]; we1 = pw[1]; addr1 = pa[1]; wdata1 = pd[1];
      #1;
      a0 = owner == 0 && pr[0];
      a1 = owner == 1 && pr[1];
      ax = a0 ? 0 : a1 ? 1 : -1;
      e_we = 0; e_re = 0; e_addr = '0; e_wd = '0;
      if (ax >= 0) begin
        e_we = pw[ax]; e_re = !pw[ax]; e_addr = pa[ax]; e_wd = pd[ax];
      end
      tests++;
      if ({gnt0, gnt1} !== {owner == 0, owner == 1}) begin
        fails++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, {gnt0, gnt1}, {owner == 0, owner == 1});
      end
      tests++;
      if ({mwe, mre, maddr, mwd} !== {e_we, e_re, e_addr, e_wd}) begin
        fails++; $display("FAIL rand_mem c%0d: got we=%b re=%b addr=%h wd=%h expected %b %b %h %h", c, mwe, mre, maddr, mwd, e_we, e_re, e_addr, e_wd);
      end
      tests++;
      if ({rv0, rv1, rd0, rd1} !== {ex_rv[0], ex_rv[1], ex_rd[0], ex_rd[1]}) begin
        fails++; $display("FAIL rand_rdata c%0d: got %b%b %h %h expected %b%b %h %h", c, rv0, rv1, rd0, rd1, ex_rv[0], ex_rv[1], ex_rd[0], ex_rd[1]);
      end
      for (int p = 0; p < 2; p++) begin
        ex_rv[p] = ax == p && !pw[p];
        if (ex_rv[p]) ex_rd[p] = ref_mem[pa[p][6:3]];
        pacc[p] = ax == p;
      end
      if (e_we) ref_mem[e_addr[6:3]] = e_wd;
      if (owner < 0) begin
        run = 0;
        if (pr[0] && pr[1]) owner = 1 - last;
        else if (pr[0]) owner = 0;
        else if (pr[1]) owner = 1;
      end else begin
        if (ax == owner) run++;
        if (!pr[owner] || (ax == owner && pr[1 - owner] && run >= BM)) begin
          last = owner;
          owner = pr[1 - owner] ? 1 - owner : -1;
          run = 0;
        end
      end
      nxt();
    end
    clr();
    nxt(); nxt();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    clr();
    test_reset();
    test_single_read();
    test_contention();
    test_solo_burst();
    test_write_read();
    test_midburst_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
